// File: rtl/mips_muldiv_ctrl_pkg.sv
// mips_muldiv_ctrl_pkg: funct/ALUOP constants, FSM and op enums, and a helper shared by the multiply/divide unit
package mips_muldiv_ctrl_pkg;
    localparam logic [1:0] ALUOP_RTYPE = 2'd2;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_e;
    function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
        return neg ? -x : x;
    endfunction
endpackage

// File: rtl/mips_muldiv_ctrl_if.sv
// mips_muldiv_ctrl_if: EX-stage signals between the pipeline and the multiply/divide controller
interface mips_muldiv_ctrl_if;
    logic [1:0]  ALUOPEX;
    logic [5:0]  Function;
    logic        ValidEX;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        STALL;
    logic        MfSel;
    logic [31:0] MfResult;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master(output ALUOPEX, Function, ValidEX, RsData, RtData,
                   input STALL, MfSel, MfResult, Busy, HI, LO);
    modport slave(input ALUOPEX, Function, ValidEX, RsData, RtData,
                  output STALL, MfSel, MfResult, Busy, HI, LO);
endinterface

// File: rtl/mips_muldiv_dp.sv
// mips_muldiv_dp: 64-bit shift-add multiply / restoring divide engine with sign correction
module mips_muldiv_dp
    import mips_muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        start,
    input  logic        step,
    input  logic        fix,
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);
    logic [31:0] acc, lo, m;
    logic        sa, sb, is_div, sgn_in, div_in, ok, bz;
    logic [32:0] add, sub;
    logic [63:0] pfix;
    assign is_div = 1'b1;
    assign sgn_in = op == OP_MULT || op == OP_DIV;
    assign div_in = op == OP_DIV || op == OP_DIVU;
    assign add    = {1'b0, acc} + {1'b0, lo[0] ? m : 32'd0};
    // acc[31] set means the shifted remainder exceeds 2^32 and always covers the divisor
    assign sub    = {1'b0, acc[30:0], lo[31]} - {1'b0, m};
    assign ok     = acc[31] | ~sub[32];
    assign bz     = m == 32'd0;
    assign pfix   = (sa ^ sb) ? -{acc, lo} : {acc, lo};
    logic div_q;
    // load magnitudes on start, then one multiply or divide iteration per step
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= '0;
            lo    <= div_in ? mag(rs, sgn_in & rs[31]) : mag(rt, sgn_in & rt[31]);
            m     <= div_in ? mag(rt, sgn_in & rt[31]) : mag(rs, sgn_in & rs[31]);
            sa    <= sgn_in & rs[31];
            sb    <= sgn_in & rt[31];
            div_q <= div_in;
        end else if (step) begin
            if (div_q)
                {acc, lo} <= ok ? {sub[31:0], lo[30:0], 1'b1} : {acc[30:0], lo, 1'b0};
            else
                {acc, lo} <= {add, lo[31:1]};
        end
    end
    // a zero divisor leaves the all-ones quotient unsigned; the remainder fix restores the raw dividend
    assign res_hi = !fix ? '0 : div_q ? mag(acc, sa) : pfix[63:32];
    assign res_lo = !fix ? '0 : div_q ? mag(lo, (sa ^ sb) && !bz) : pfix[31:0];
    logic unused_ok;
    assign unused_ok = is_div;
endmodule

// File: rtl/mips_muldiv_ctrl.sv
// mips_muldiv_ctrl: EX-stage MULT/DIV/MFxx/MTxx decode, sequencing FSM, stall and HI/LO registers
module mips_muldiv_ctrl
    import mips_muldiv_ctrl_pkg::*;
(
    input logic clk,
    input logic reset,
    mips_muldiv_ctrl_if.slave bus
);
    state_e      state, state_n;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, res_hi, res_lo;
    logic        dec, is_md, is_mx, start, step, fix, idle;
    logic [5:0]  fn;
    assign fn    = bus.Function;
    assign dec   = bus.ValidEX && bus.ALUOPEX == ALUOP_RTYPE;
    assign is_md = dec && fn[5:2] == FN_MULT[5:2];
    assign is_mx = dec && fn[5:2] == FN_MFHI[5:2];
    assign idle  = state == IDLE;
    assign start = is_md && idle;
    assign step  = state == RUN;
    assign fix   = state == FIX;
    assign bus.STALL    = (is_md || is_mx) && !idle;
    assign bus.MfSel    = dec && (fn == FN_MFHI || fn == FN_MFLO);
    assign bus.MfResult = !dec ? '0 : fn == FN_MFHI ? hi : fn == FN_MFLO ? lo : '0;
    assign bus.Busy     = !idle;
    assign bus.HI       = hi;
    assign bus.LO       = lo;
    mips_muldiv_dp u_dp (
        .clk(clk), .start(start), .step(step), .fix(fix),
        .op(md_op_e'(fn[1:0])), .rs(bus.RsData), .rt(bus.RtData),
        .res_hi(res_hi), .res_lo(res_lo)
    );
    // state and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= step ? cnt + 5'd1 : 5'd0;
        end
    end
    // IDLE -> RUN on a start, 32 RUN iterations, one FIX cycle
    always_comb begin
        state_n = state;
        state_n = idle ? (start ? RUN : IDLE) : step ? (cnt == 5'd31 ? FIX : RUN) : IDLE;
    end
    // HI/LO take the engine result in FIX or an MTHI/MTLO accepted in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (idle && dec) begin
            if (fn == FN_MTHI) hi <= bus.RsData;
            if (fn == FN_MTLO) lo <= bus.RsData;
        end
    end
endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// tb_mips_muldiv_ctrl: directed vector table plus multi-cycle stall/reset sequences
module tb_mips_muldiv_ctrl;
    import mips_muldiv_ctrl_pkg::*;
    logic clk = 0;
    logic reset = 1;
    int ncmp = 0;
    int nerr = 0;
    mips_muldiv_ctrl_if bus();
    mips_muldiv_ctrl dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        bus.ValidEX = v;
        bus.ALUOPEX = aop;
        bus.Function = fn;
        bus.RsData = rs;
        bus.RtData = rt;
        #1;
    endtask
    task automatic count_while(input bit use_stall, output int n);
        n = 0;
        while ((use_stall ? bus.STALL : bus.Busy) && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask
    int n;
    initial begin
        vecs[0] = '{FN_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{FN_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4] = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6] = '{FN_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[7] = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        chk("reset Busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset STALL", {31'd0, bus.STALL}, 32'd0);
        chk("reset MfSel", {31'd0, bus.MfSel}, 32'd0);
        chk("reset MfResult", bus.MfResult, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1, ALUOP_RTYPE, vecs[i].fn, vecs[i].rs, vecs[i].rt);
            chk($sformatf("v%0d start STALL", i), {31'd0, bus.STALL}, 32'd0);
            drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
            count_while(0, n);
            chk($sformatf("v%0d busy cycles", i), n, 33);
            chk($sformatf("v%0d HI", i), bus.HI, vecs[i].hi);
            chk($sformatf("v%0d LO", i), bus.LO, vecs[i].lo);
        end
        drive(1, 2'd0, FN_MULT, 32'd3, 32'd5);
        drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
        chk("aluop0 no start", {31'd0, bus.Busy}, 32'd0);
        drive(1, ALUOP_RTYPE, FN_MULT, 32'd6, 32'd7);
        drive(0, ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0);
        chk("bubble STALL", {31'd0, bus.STALL}, 32'd0);
        chk("bubble MfSel", {31'd0, bus.MfSel}, 32'd0);
        chk("bubble MfResult", bus.MfResult, 32'd0);
        count_while(0, n);
        chk("mult2 busy cycles", n, 33);
        drive(1, ALUOP_RTYPE, FN_MULT, 32'd6, 32'd7);
        drive(1, ALUOP_RTYPE, FN_MFLO, 32'd0, 32'd0);
        count_while(1, n);
        chk("mflo stall cycles", n, 33);
        chk("mflo MfSel", {31'd0, bus.MfSel}, 32'd1);
        chk("mflo MfResult", bus.MfResult, 32'h0000002A);
        drive(1, ALUOP_RTYPE, FN_MULT, 32'h00010000, 32'h00010000);
        drive(1, ALUOP_RTYPE, FN_MTLO, 32'h12345678, 32'd0);
        count_while(1, n);
        chk("mtlo stall cycles", n, 33);
        chk("mtlo LO before write", bus.LO, 32'd0);
        drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
        chk("mtlo LO", bus.LO, 32'h12345678);
        chk("mtlo HI kept", bus.HI, 32'd1);
        drive(1, ALUOP_RTYPE, FN_MTHI, 32'hABCD0123, 32'd0);
        drive(1, ALUOP_RTYPE, FN_MFHI, 32'd0, 32'd0);
        chk("mfhi STALL", {31'd0, bus.STALL}, 32'd0);
        chk("mfhi MfSel", {31'd0, bus.MfSel}, 32'd1);
        chk("mfhi MfResult", bus.MfResult, 32'hABCD0123);
        drive(0, ALUOP_RTYPE, FN_MTHI, 32'h55555555, 32'd0);
        drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
        chk("bubble MTHI ignored", bus.HI, 32'hABCD0123);
        drive(1, ALUOP_RTYPE, FN_MULT, 32'h00001234, 32'h00005678);
        drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        #1;
        reset = 0;
        chk("rst mid Busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst mid STALL", {31'd0, bus.STALL}, 32'd0);
        chk("rst mid HI", bus.HI, 32'd0);
        chk("rst mid LO", bus.LO, 32'd0);
        drive(1, ALUOP_RTYPE, FN_MULT, 32'd3, 32'd5);
        drive(0, 2'd0, 6'd0, 32'd0, 32'd0);
        count_while(0, n);
        chk("post rst busy cycles", n, 33);
        chk("post rst HI", bus.HI, 32'd0);
        chk("post rst LO", bus.LO, 32'h0000000F);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
